sha256_msg_padder: RTL

//  Upstream stage of the sequential SHA-256 core. Collects a message byte-stream into a

---
 rtl/sha256_pkg.sv | 22 ++
 rtl/sha256_msg_padder_if.sv | 29 ++
 rtl/sha256_msg_padder.sv | 110 +++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padder.
// Combinational only: no latency.
// No flow control lives here.
package sha256_pkg;

  localparam int BLOCK_W   = 512;
  localparam int LEN_W     = 64;
  localparam int CNT_W     = 6;
  // Bytes in front of the 64-bit length field
  localparam int PAD_LIMIT = 56;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    PAD,
    START,
    WAIT,
    ERR
  } padder_state_t;

endpackage

// File: rtl/sha256_msg_padder_if.sv
// Byte-stream and block handshake between a message source, the padder and the core.
// No latency: wires only.
// The source holds byte_in/byte_valid until byte_ready is seen high.
interface sha256_msg_padder_if;
  import sha256_pkg::*;

  logic [7:0]         byte_in;
  logic               byte_valid;
  logic               byte_ready;
  logic               msg_end;
  logic [BLOCK_W-1:0] block;
  logic               start;
  logic               core_done;
  logic               busy;
  logic               err;

  // Message source and core side
  modport master (
    output byte_in, byte_valid, msg_end, core_done,
    input  byte_ready, block, start, busy, err
  );

  // Padder side
  modport slave (
    input  byte_in, byte_valid, msg_end, core_done,
    output byte_ready, block, start, busy, err
  );

endinterface

// File: rtl/sha256_msg_padder.sv
// Packs a byte stream into one 512-bit block with SHA-256 padding and starts the core.
// Latency: msg_end in cycle N gives a one-cycle start in cycle N+2.
// byte_ready drops outside IDLE/COLLECT and when the block is full; overflow is sticky until rst.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int MAX_BYTES = 55
) (
  input logic               sysclk_125mhz,
  input logic               rst,
  sha256_msg_padder_if.slave bus
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

  padder_state_t      state;
  logic [CNT_W-1:0]   count;
  logic [BLOCK_W-1:0] block_q;
  logic               start_q;
  logic               err_q;
  logic               core_done_q;

  logic               byte_ready;
  logic               accept;
  logic               overflow;
  logic [8:0]         lane_lsb;

  // Byte lane addressed by count: byte 0 sits in the top lane
  assign lane_lsb   = 9'(BLOCK_W - 8) - {count, 3'b000};

  assign byte_ready = (state == IDLE) || ((state == COLLECT) && (count < MAX_CNT));
  assign accept     = bus.byte_valid && byte_ready;
  // A byte offered once the block is full is dropped, even if msg_end comes with it
  assign overflow   = (state == COLLECT) && bus.byte_valid && (count == MAX_CNT);

  assign bus.byte_ready = byte_ready;
  assign bus.block      = block_q;
  assign bus.start      = start_q;
  assign bus.err        = err_q;
  assign bus.busy       = (state != IDLE) && (state != ERR);

  // Padder FSM: collect bytes, pad in place, pulse start, wait for a rising core_done
  always_ff @(posedge sysclk_125mhz or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      block_q     <= '0;
      start_q     <= 1'b0;
      err_q       <= 1'b0;
      core_done_q <= 1'b0;
    end else begin
      core_done_q <= bus.core_done;
      start_q     <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            block_q[lane_lsb +: 8] <= bus.byte_in;
            count                  <= CNT_W'(1);
            state                  <= bus.msg_end ? PAD : COLLECT;
          end else if (bus.msg_end) begin
            state <= PAD;
          end
        end
        COLLECT: begin
          if (overflow) begin
            err_q <= 1'b1;
            state <= ERR;
          end else begin
            if (accept) begin
              block_q[lane_lsb +: 8] <= bus.byte_in;
              count                  <= count + CNT_W'(1);
            end
            if (bus.msg_end) begin
              state <= PAD;
            end
          end
        end
        PAD: begin
          // Stale bytes from earlier messages are cleared only here
          for (int i = 0; i < PAD_LIMIT; i++) begin
            if (i > int'(count)) begin
              block_q[BLOCK_W - 8 - 8*i +: 8] <= 8'h00;
            end
          end
          block_q[lane_lsb +: 8]  <= PAD_BYTE;
          block_q[LEN_W-1:0]      <= LEN_W'({count, 3'b000});
          start_q                 <= 1'b1;
          state                   <= START;
        end
        START: begin
          state <= WAIT;
        end
        WAIT: begin
          // core_done_q was sampled during START, so a level already high is ignored
          if (bus.core_done && !core_done_q) begin
            count <= '0;
            state <= IDLE;
          end
        end
        ERR: begin
          state <= ERR;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
